// File: rtl/softmax_vec_serializer_if.sv
// Element-stream interface: a whole softmax vector arrives on one strobe, and
// lanes leave one at a time under a valid/ready handshake.
interface softmax_vec_serializer_if #(
    parameter int N         = 32,
    parameter int BIT_WIDTH = 16
);
    logic                   i_valid;
    logic [BIT_WIDTH-1:0]   i_data [N-1:0];
    logic                   o_valid;
    logic [BIT_WIDTH-1:0]   o_data;
    logic [$clog2(N)-1:0]   o_idx;
    logic                   o_last;
    logic                   i_ready;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_valid, o_data, o_idx, o_last
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_valid, o_data, o_idx, o_last
    );
endinterface

// File: rtl/softmax_vec_serializer.sv
// Buffers whole softmax vectors in a small FIFO and streams them out lane by
// lane; a vector arriving with no free slot is dropped and flagged sticky.
module softmax_vec_serializer #(
    parameter int N         = 32,
    parameter int BIT_WIDTH = 16,
    parameter int DEPTH     = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    softmax_vec_serializer_if.slave     bus,
    output logic [$clog2(DEPTH):0]      o_vec_count,
    output logic                        o_full,
    output logic                        o_overflow,
    input  logic                        i_clear_ovf
);
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [BIT_WIDTH-1:0] mem [DEPTH][N];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [IW-1:0]        elem_idx;
    logic [CW-1:0]        count;
    logic                 pop;
    logic                 pop_last;
    logic                 accept;
    logic                 drop;

    // A slot freed by the final beat of the head vector can be refilled on the same edge.
    always_comb begin
        pop      = bus.o_valid && bus.i_ready;
        pop_last = pop && (elem_idx == IW'(N - 1));
        accept   = bus.i_valid && ((count < CW'(DEPTH)) || pop_last);
        drop     = bus.i_valid && !accept;
    end

    assign bus.o_valid = (count != '0);
    assign bus.o_data  = mem[rd_ptr][elem_idx];
    assign bus.o_idx   = elem_idx;
    assign bus.o_last  = bus.o_valid && (elem_idx == IW'(N - 1));
    assign o_vec_count = count;
    assign o_full      = (count == CW'(DEPTH));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            elem_idx   <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
            for (int d = 0; d < DEPTH; d++) begin
                for (int n = 0; n < N; n++) begin
                    mem[d][n] <= '0;
                end
            end
        end else begin
            if (accept) begin
                for (int n = 0; n < N; n++) begin
                    mem[wr_ptr][n] <= bus.i_data[n];
                end
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_last) begin
                elem_idx <= '0;
                rd_ptr   <= rd_ptr + PW'(1);
            end else if (pop) begin
                elem_idx <= elem_idx + IW'(1);
            end
            count <= count + CW'(accept) - CW'(pop_last);
            // A drop in the same cycle as a clear request keeps the flag set.
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clear_ovf) begin
                o_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_softmax_vec_serializer.sv
// Directed bench: a queue-of-vectors model checked every cycle, plus recorded
// output streams compared against hand-built vectors.
module tb_softmax_vec_serializer;
    localparam int N     = 32;
    localparam int BW    = 16;
    localparam int DEPTH = 2;

    typedef logic [BW-1:0] vec_t [N-1:0];

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clear_ovf = 1'b0;
    logic [$clog2(DEPTH):0] vec_count;
    logic                  full;
    logic                  overflow;

    softmax_vec_serializer_if #(.N(N), .BIT_WIDTH(BW)) bus();

    softmax_vec_serializer #(.N(N), .BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_vec_count (vec_count),
        .o_full      (full),
        .o_overflow  (overflow),
        .i_clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int peak     = 0;

    vec_t mq[$];
    int   m_idx = 0;
    bit   m_ovf = 1'b0;
    bit   m_pop, m_pl, m_acc;

    logic [BW-1:0] rec_data[$];
    int            rec_idx[$];
    bit            rec_last[$];
    int            rec_cyc[$];
    vec_t          expq[$];

    bit toggle_mode = 1'b0;
    int phase = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t make_vec(input int base, input int step);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = BW'(base + step * i);
        return v;
    endfunction

    // Model: a FIFO of whole vectors and the lane position within the head vector.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_idx = 0;
            m_ovf = 1'b0;
        end else begin
            m_pop = (mq.size() != 0) && bus.i_ready;
            m_pl  = m_pop && (m_idx == N - 1);
            m_acc = bus.i_valid && ((mq.size() < DEPTH) || m_pl);
            if (m_pl) begin
                void'(mq.pop_front());
                m_idx = 0;
            end else if (m_pop) begin
                m_idx++;
            end
            if (m_acc) mq.push_back(bus.i_data);
            if (clear_ovf) m_ovf = 1'b0;
            if (bus.i_valid && !m_acc) m_ovf = 1'b1;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        check("o_valid", bus.o_valid, mq.size() != 0);
        check("o_idx", bus.o_idx, m_idx);
        check("o_last", bus.o_last, (mq.size() != 0) && (m_idx == N - 1));
        check("o_vec_count", vec_count, mq.size());
        check("o_full", full, mq.size() == DEPTH);
        check("o_overflow", overflow, m_ovf);
        if (mq.size() != 0) check("o_data", bus.o_data, mq[0][m_idx]);
        if (bus.o_valid && bus.i_ready && !rst) begin
            rec_data.push_back(bus.o_data);
            rec_idx.push_back(bus.o_idx);
            rec_last.push_back(bus.o_last);
            rec_cyc.push_back(cyc);
        end
        if (int'(vec_count) > peak) peak = int'(vec_count);
    end

    // Ready pattern 1,0,0,1 repeating while toggle_mode is on.
    always @(posedge clk) begin
        #2;
        if (toggle_mode) begin
            bus.i_ready = (phase == 0 || phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    task automatic clear_rec();
        rec_data.delete(); rec_idx.delete(); rec_last.delete(); rec_cyc.delete();
        expq.delete();
    endtask

    task automatic strobe(input vec_t v);
        @(posedge clk); #2;
        bus.i_valid = 1'b1;
        bus.i_data  = v;
        @(posedge clk); #2;
        bus.i_valid = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #2;
        bus.i_ready = r;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #2; clear_ovf = 1'b1;
        @(posedge clk); #2; clear_ovf = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (vec_count != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", vec_count, 0);
        @(negedge clk);
    endtask

    task automatic wait_lane(input int lane, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.o_valid && bus.o_idx == lane) && n < budget);
        check("lane_timeout", bus.o_idx, lane);
    endtask

    task automatic check_stream(input string name);
        check({name, "_beats"}, rec_data.size(), expq.size() * N);
        for (int b = 0; b < expq.size() * N && b < rec_data.size(); b++) begin
            check({name, "_data"}, rec_data[b], expq[b / N][b % N]);
            check({name, "_idx"}, rec_idx[b], b % N);
            check({name, "_last"}, rec_last[b], (b % N) == N - 1);
        end
    endtask

    vec_t va, vb, vc, vd, ve;

    initial begin
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_data  = make_vec(0, 0);
        repeat (2) @(negedge clk);
        check("rst_valid", bus.o_valid, 0);
        check("rst_count", vec_count, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_idx", bus.o_idx, 0);
        check("rst_last", bus.o_last, 0);
        rst = 1'b0;

        // Single vector, lanes 100*i, consumer always ready
        va = make_vec(0, 100);
        set_ready(1'b1);
        clear_rec();
        @(posedge clk); #2;
        bus.i_valid = 1'b1; bus.i_data = va;
        check("t1_pre_valid", bus.o_valid, 0);
        @(posedge clk); #2;
        bus.i_valid = 1'b0;
        check("t1_latency", bus.o_valid, 1);
        check("t1_first_data", bus.o_data, 0);
        check("t1_count", vec_count, 1);
        wait_drain(100);
        expq.push_back(va);
        check_stream("t1");
        check("t1_lane31", rec_data[31], 3100);
        check("t1_lane7", rec_data[7], 700);

        // Same vector under a 1,0,0,1 ready pattern
        set_ready(1'b0);
        clear_rec();
        phase = 0;
        toggle_mode = 1'b1;
        strobe(va);
        wait_drain(300);
        toggle_mode = 1'b0;
        expq.push_back(va);
        check_stream("t2");

        // Two vectors three cycles apart, back to back on the output
        set_ready(1'b1);
        clear_rec();
        peak = 0;
        va = make_vec(0, 1);
        vb = make_vec(1000, 1);
        strobe(va);
        @(posedge clk);
        strobe(vb);
        wait_drain(200);
        expq.push_back(va); expq.push_back(vb);
        check_stream("t3");
        check("t3_contig", rec_cyc[63] - rec_cyc[0], 63);
        check("t3_peak", peak, 2);
        check("t3_ovf", overflow, 0);
        check("t3_B0", rec_data[32], 1000);

        // Overflow: three strobes with the consumer stalled
        set_ready(1'b0);
        clear_rec();
        va = make_vec(10, 3);
        vb = make_vec(20000, 7);
        vc = make_vec(555, 1);
        strobe(va);
        check("t4_full1", full, 0);
        strobe(vb);
        check("t4_full2", full, 1);
        strobe(vc);
        check("t4_ovf", overflow, 1);
        check("t4_count", vec_count, 2);
        set_ready(1'b1);
        wait_drain(200);
        expq.push_back(va); expq.push_back(vb);
        check_stream("t4");
        pulse_clear();
        check("t4_cleared", overflow, 0);
        set_ready(1'b0);
        strobe(va);
        strobe(vb);
        @(posedge clk); #2;
        bus.i_valid = 1'b1; bus.i_data = vc; clear_ovf = 1'b1;
        @(posedge clk); #2;
        bus.i_valid = 1'b0; clear_ovf = 1'b0;
        check("t4_set_wins", overflow, 1);
        set_ready(1'b1);
        wait_drain(200);
        pulse_clear();
        check("t4_cleared2", overflow, 0);

        // Full buffer, new vector coincides with the head's final beat
        set_ready(1'b0);
        vd = make_vec(300, 2);
        ve = make_vec(4000, 5);
        vc = make_vec(60000, 11);
        strobe(vd);
        strobe(ve);
        check("t5_full", full, 1);
        clear_rec();
        set_ready(1'b1);
        wait_lane(31, 100);
        bus.i_valid = 1'b1; bus.i_data = vc;
        @(posedge clk); #2;
        bus.i_valid = 1'b0;
        check("t5_ovf", overflow, 0);
        check("t5_count", vec_count, 2);
        wait_drain(200);
        expq.push_back(vd); expq.push_back(ve); expq.push_back(vc);
        check_stream("t5");

        // Reset in the middle of a vector with another buffered
        va = make_vec(7, 9);
        vb = make_vec(900, 4);
        strobe(va);
        strobe(vb);
        wait_lane(10, 100);
        #1 rst = 1'b1;
        #1;
        check("t6_valid", bus.o_valid, 0);
        check("t6_count", vec_count, 0);
        check("t6_ovf", overflow, 0);
        check("t6_data", bus.o_data, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_rec();
        vc = make_vec(123, 13);
        strobe(vc);
        wait_drain(100);
        expq.push_back(vc);
        check_stream("t6");
        check("t6_lane0", rec_data[0], 123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/softmax_vec_serializer.md
Name: softmax_vec_serializer

Overview:
Sits downstream of the 32-lane softmax pipeline and converts each full output vector into an element-by-element stream.
- Input: one-cycle o_valid pulse carrying N Q0.16 unsigned lanes from the softmax block. That interface has no backpressure.
- Output: elements 0..N-1 in order, each with a valid/ready handshake.
- A small vector FIFO absorbs softmax vectors while the consumer stalls; overflow is flagged.

Parameters:
N, 32, lanes per vector (power of two, >=2)
BIT_WIDTH, 16, bits per element (Q0.16 unsigned)
DEPTH, 2, vector slots in the buffer (power of two, >=2)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_valid  input  1  one-cycle strobe: i_data holds a complete softmax vector
i_data  input  N x BIT_WIDTH (unpacked [N-1:0])  softmax output vector, lane 0 streamed first
o_valid  output  1  o_data holds a valid element
o_data  output  BIT_WIDTH  current element
o_idx  output  $clog2(N)  lane index of o_data
o_last  output  1  high with o_valid when o_idx == N-1
i_ready  input  1  consumer accepts element when o_valid && i_ready
o_vec_count  output  $clog2(DEPTH)+1  vectors held, including the one being streamed
o_full  output  1  o_vec_count == DEPTH
o_overflow  output  1  sticky: a vector was dropped
i_clear_ovf  input  1  synchronous clear of o_overflow

Behaviour:
- Reset (async assert): wr_ptr, rd_ptr, elem_idx, count and o_overflow are 0. Outputs are o_valid=0, o_idx=0, o_last=0, o_vec_count=0, o_full=0, o_overflow=0. o_data=0 because storage is zeroed.
- Storage: DEPTH x N x BIT_WIDTH registers, written whole-vector; wr_ptr/rd_ptr wrap modulo DEPTH.
- Definitions:
  - pop = o_valid && i_ready.
  - pop_last = pop && elem_idx == N-1.
  - accept = i_valid && (count < DEPTH || pop_last).
- Write: on accept, slot[wr_ptr] <= i_data and wr_ptr++. i_data is sampled only on the strobe cycle.
- Drop: i_valid && !accept. The vector is discarded; storage and pointers are unchanged; o_overflow <= 1.
- Overflow clear: i_clear_ovf clears o_overflow. If a drop occurs in the same cycle, the set wins.
- Read outputs:
  - o_valid = (count != 0).
  - o_data = slot[rd_ptr][elem_idx], a mux from registered storage with no extra register stage.
  - o_idx = elem_idx.
  - o_last = o_valid && elem_idx == N-1.
- Handshake:
  - On pop, elem_idx++.
  - On pop_last, elem_idx <= 0 and rd_ptr++.
  - While o_valid && !i_ready, o_data, o_idx and o_last stay stable.
- Count: count <= count + accept - pop_last. Simultaneous accept and pop_last leaves count unchanged; both pointers move.
- Latency: a vector strobed at edge k gives first element o_valid at cycle k+1 if the buffer was empty. Throughput is one element per cycle.
- Back-to-back vectors: no bubble between lane N-1 of one vector and lane 0 of the next.
- Full with i_valid coincident with pop_last: accepted, because the slot frees that same edge.
- Full with i_valid and no pop_last: dropped.
- i_valid is ignored during reset.
- Reset mid-stream: the partially sent vector and all buffered vectors are discarded; o_valid falls asynchronously.
- Sustained rate: the softmax may strobe at most once per N cycles without loss when i_ready is held high. Higher rates rely on DEPTH.

Test Plan:
1. Single vector, lane i = 100*i, i_ready=1, strobe at edge k.
   - o_valid rises at k+1.
   - 32 consecutive beats with o_data = 0,100,...,3100 and o_idx 0..31.
   - o_last only on beat 32; o_vec_count goes 1 then 0.
2. Backpressure on the same vector: i_ready toggled 1,0,0,1 repeating.
   - Exactly 32 accepted beats, in order.
   - o_data and o_idx constant across each stall.
   - No duplicated or skipped lanes.
3. Two vectors A (lanes = i) and B (lanes = 1000+i), strobes 3 cycles apart, i_ready=1.
   - 64 contiguous beats: A0..A31 then B0..B31 with no gap.
   - o_vec_count peaks at 2; o_overflow stays 0.
4. Overflow with DEPTH=2: three strobes while i_ready=0.
   - o_full=1 after the second strobe; the third is dropped and o_overflow=1.
   - Raise i_ready: only vectors 1 and 2 emerge.
   - Pulse i_clear_ovf: o_overflow returns to 0.
   - Clear coincident with a new drop: o_overflow remains 1.
5. Buffer full; strobe vector C on the cycle lane 31 of the head vector is accepted.
   - C is accepted, o_overflow stays 0, o_vec_count stays 2.
   - C streams after the remaining buffered vector.
6. Assert i_rst at lane 10 of a vector with a second vector buffered.
   - o_valid=0 immediately; o_vec_count=0, o_overflow=0.
   - A new vector strobed after deassert streams from lane 0 with correct data.
